// File: rtl/ca149_pkg.sv
// Shared definitions for the rule-149 cellular-automaton PRNG path: FSM state
// encoding and the step function used by generator and checker alike.
package ca149_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } ca149_state_t;

  localparam int CA149_MAX_N = 64;
  localparam int CA149_IW    = $clog2(CA149_MAX_N);

  // One rule-149 step on the low n bits of x (ring topology); bits >= n return 0.
  function automatic logic [CA149_MAX_N-1:0] ca149_step(input logic [CA149_MAX_N-1:0] x,
                                                        input int n);
    logic [CA149_MAX_N-1:0] y;
    int up;
    int dn;
    y = '0;
    for (int i = 0; i < CA149_MAX_N; i++) begin
      if (i < n) begin
        up = (i + 1 == n) ? 0 : i + 1;
        dn = (i == 0) ? n - 1 : i - 1;
        y[CA149_IW'(i)] = ~((x[CA149_IW'(up)] & x[CA149_IW'(i)]) ^ x[CA149_IW'(dn)]);
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/ca149_stream_checker_if.sv
// Word stream from a PRNG source into the checker; the sink is always ready.
interface ca149_stream_checker_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic [N-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/ca149_stream_checker.sv
// Self-seeding receive checker for the rule-149 PRNG stream: hunts, acquires,
// flywheels while locked, and reports pulses plus saturating counters.
module ca149_stream_checker
  import ca149_pkg::*;
#(
  parameter int N          = 32,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  ca149_stream_checker_if.slave   s_if,
  output logic                    locked_o,
  output logic [1:0]              state_o,
  output logic                    match_pulse_o,
  output logic                    err_pulse_o,
  output logic                    lost_pulse_o,
  output logic [CNT_W-1:0]        err_count_o,
  output logic [CNT_W-1:0]        word_count_o,
  output logic [N-1:0]            expected_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  ca149_state_t   state_q, state_d;
  logic [N-1:0]   exp_q, exp_d;
  logic [MW-1:0]  match_cnt_q, match_cnt_d;
  logic [LW-1:0]  miss_cnt_q, miss_cnt_d;
  logic           match_q, match_d;
  logic           err_q, err_d;
  logic           lost_q, lost_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic [N-1:0]   step_w;
  logic [N-1:0]   step_e;
  logic           hit;
  logic [MW-1:0]  match_inc;
  logic [LW-1:0]  miss_inc;

  // Successor of the received word (reseed) and of the prediction (flywheel).
  assign step_w    = N'(ca149_step(CA149_MAX_N'(s_if.in_data), N));
  assign step_e    = N'(ca149_step(CA149_MAX_N'(exp_q), N));
  assign hit       = (s_if.in_data == exp_q);
  assign match_inc = match_cnt_q + MW'(1);
  assign miss_inc  = miss_cnt_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    match_d     = 1'b0;
    err_d       = 1'b0;
    lost_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (s_if.in_valid) begin
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
      unique case (state_q)
        HUNT: begin
          exp_d       = step_w;
          match_cnt_d = '0;
          state_d     = ACQ;
        end
        ACQ: begin
          exp_d = step_w;
          if (hit) begin
            match_d = 1'b1;
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_inc;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Never resync from received data while locked: run on the prediction.
          exp_d = step_e;
          if (hit) begin
            match_d    = 1'b1;
            miss_cnt_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (miss_inc == LW'(LOSS_COUNT)) begin
              lost_d      = 1'b1;
              state_d     = ACQ;
              exp_d       = step_w;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_i) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      lost_q      <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      match_q     <= match_d;
      err_q       <= err_d;
      lost_q      <= lost_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign locked_o      = (state_q == LOCKED);
  assign state_o       = state_q;
  assign match_pulse_o = match_q;
  assign err_pulse_o   = err_q;
  assign lost_pulse_o  = lost_q;
  assign err_count_o   = err_cnt_q;
  assign word_count_o  = word_cnt_q;
  assign expected_o    = exp_q;

endmodule

// File: tb/tb_ca149_stream_checker.sv
// Scoreboard bench for ca149_stream_checker: a driver pushes the reference
// model's expected outputs per cycle, a monitor pops and compares them.
module tb_ca149_stream_checker;

  localparam int N          = 8;
  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;
  localparam int CNT_W      = 3;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear_i = 1'b0;
  logic             locked_o;
  logic [1:0]       state_o;
  logic             match_pulse_o;
  logic             err_pulse_o;
  logic             lost_pulse_o;
  logic [CNT_W-1:0] err_count_o;
  logic [CNT_W-1:0] word_count_o;
  logic [N-1:0]     expected_o;

  ca149_stream_checker_if #(.N(N)) s_if ();

  ca149_stream_checker #(
    .N(N), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .s_if(s_if),
    .locked_o(locked_o), .state_o(state_o), .match_pulse_o(match_pulse_o),
    .err_pulse_o(err_pulse_o), .lost_pulse_o(lost_pulse_o),
    .err_count_o(err_count_o), .word_count_o(word_count_o), .expected_o(expected_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v;
    logic [N-1:0]     d;
    logic [1:0]       st;
    bit               locked;
    bit               match;
    bit               err;
    bit               lost;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] wc;
    logic [N-1:0]     ex;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ntx = 0;

  // Reference model state: 0 hunting, 1 acquiring, 2 locked.
  int               m_st;
  int               m_run;
  int               m_miss;
  logic [N-1:0]     m_exp;
  logic [CNT_W-1:0] m_ec;
  logic [CNT_W-1:0] m_wc;
  logic [N-1:0]     gen;
  logic [N-1:0]     last_bad;

  // Rule 149 written with ring rotations: left neighbour x[i+1], right neighbour x[i-1].
  function automatic logic [N-1:0] fstep(input logic [N-1:0] x);
    logic [N-1:0] nxt;
    logic [N-1:0] prv;
    nxt = (x >> 1) | (x << (N - 1));
    prv = (x << 1) | (x >> (N - 1));
    return ~((nxt & x) ^ prv);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  task automatic model_reset();
    m_st = 0; m_run = 0; m_miss = 0; m_exp = '0; m_ec = '0; m_wc = '0;
  endtask

  task automatic model_step(input bit v, input logic [N-1:0] w, input bit clr, output exp_t e);
    e.v = v; e.d = w; e.match = 0; e.err = 0; e.lost = 0;
    if (v) begin
      if (m_wc != CMAX) m_wc = m_wc + 1'b1;
      if (m_st == 0) begin
        m_exp = fstep(w); m_run = 0; m_st = 1;
      end else if (m_st == 1) begin
        if (w == m_exp) begin
          e.match = 1; m_run++;
          if (m_run == LOCK_COUNT) begin m_st = 2; m_miss = 0; end
        end else begin
          m_run = 0;
        end
        m_exp = fstep(w);
      end else begin
        if (w == m_exp) begin
          e.match = 1; m_miss = 0; m_exp = fstep(m_exp);
        end else begin
          e.err = 1; m_miss++;
          if (m_ec != CMAX) m_ec = m_ec + 1'b1;
          if (m_miss == LOSS_COUNT) begin
            e.lost = 1; m_st = 1; m_run = 0; m_exp = fstep(w);
          end else begin
            m_exp = fstep(m_exp);
          end
        end
      end
    end
    if (clr) begin m_ec = '0; m_wc = '0; end
    e.st = 2'(m_st); e.locked = (m_st == 2); e.ec = m_ec; e.wc = m_wc; e.ex = m_exp;
  endtask

  task automatic cyc(input bit v, input logic [N-1:0] d, input bit clr);
    exp_t e;
    @(negedge clk);
    s_if.in_valid = v; s_if.in_data = d; clear_i = clr;
    model_step(v, d, clr, e);
    sb.push_back(e);
  endtask

  task automatic send_good(input bit clr);
    cyc(1'b1, gen, clr);
    gen = fstep(gen);
  endtask

  task automatic send_bad(input logic [N-1:0] mask, input bit clr);
    last_bad = gen ^ mask;
    cyc(1'b1, last_bad, clr);
    gen = fstep(gen);
  endtask

  // Point at which the most recently driven word's result is visible.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_locked"}, 32'(locked_o), 0);
    chk({tag, "_errcnt"}, 32'(err_count_o), 0);
    chk({tag, "_wordcnt"}, 32'(word_count_o), 0);
    chk({tag, "_expected"}, 32'(expected_o), 0);
    chk({tag, "_pulses"}, 32'({match_pulse_o, err_pulse_o, lost_pulse_o}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_if.in_valid = 1'b0; clear_i = 1'b0; reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    s_if.in_valid = 1'b1; s_if.in_data = N'($urandom);
    @(negedge clk);
    s_if.in_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  // Monitor: one expected entry per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        ntx++;
        $display("[TB] txn %0d v=%0b d=%02h state=%0d lock=%0b m/e/l=%0b%0b%0b ec=%0d wc=%0d exp=%02h",
                 ntx, e.v, e.d, state_o, locked_o, match_pulse_o, err_pulse_o, lost_pulse_o,
                 err_count_o, word_count_o, expected_o);
        chk("state", 32'(state_o), 32'(e.st));
        chk("locked", 32'(locked_o), 32'(e.locked));
        chk("match_pulse", 32'(match_pulse_o), 32'(e.match));
        chk("err_pulse", 32'(err_pulse_o), 32'(e.err));
        chk("lost_pulse", 32'(lost_pulse_o), 32'(e.lost));
        chk("err_count", 32'(err_count_o), 32'(e.ec));
        chk("word_count", 32'(word_count_o), 32'(e.wc));
        chk("expected", 32'(expected_o), 32'(e.ex));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit clr;
    int r;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    model_reset();

    // Reset held with random traffic on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_if.in_valid = 1'($urandom); s_if.in_data = N'($urandom);
      #1;
      check_reset_values("reset");
    end
    @(negedge clk);
    s_if.in_valid = 1'b0;
    reset_n = 1'b1;

    // Acquire from 01: ACQ after word 1, locked after word 5.
    gen = 8'h01;
    send_good(1'b0);
    settle();
    chk("acq_after_w1", 32'(state_o), 1);
    for (int i = 0; i < 4; i++) send_good(1'b0);
    settle();
    chk("locked_after_w5", 32'(locked_o), 1);
    chk("wordcnt_after_w5", 32'(word_count_o), 5);
    for (int i = 0; i < 3; i++) send_good(1'b0);

    // Single error then flywheel recovery.
    send_bad(8'h10, 1'b0);
    settle();
    chk("single_err_locked", 32'(locked_o), 1);
    chk("single_err_count", 32'(err_count_o), 1);
    send_good(1'b0);
    settle();
    chk("flywheel_match", 32'(match_pulse_o), 1);

    // Loss of lock on the third consecutive miss, then reseed and relock.
    for (int i = 0; i < LOSS_COUNT; i++) send_bad(N'($urandom_range(1, 255)), 1'b0);
    settle();
    chk("loss_pulse", 32'(lost_pulse_o), 1);
    chk("loss_state", 32'(state_o), 1);
    chk("loss_errcnt", 32'(err_count_o), 4);
    gen = fstep(last_bad);
    for (int i = 0; i < LOCK_COUNT; i++) send_good(1'b0);
    settle();
    chk("relock", 32'(locked_o), 1);

    // Clear coincident with an error wins.
    send_bad(8'h10, 1'b1);
    settle();
    chk("clear_vs_err", 32'(err_count_o), 0);
    send_good(1'b0);

    // Random bubbles, clears and sparse errors.
    for (int i = 0; i < 250; i++) begin
      clr = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 15);
      if (r < 4) cyc(1'b0, N'($urandom), clr);
      else if (r == 4) send_bad(N'($urandom_range(1, 255)), clr);
      else send_good(clr);
    end

    // Asynchronous reset mid-stream, then stuck-high stream locks on the fixed point.
    do_reset();
    gen = 8'hFF;
    for (int i = 0; i < 5; i++) send_good(1'b0);
    settle();
    chk("ff_locked", 32'(locked_o), 1);

    // Ten errors without losing lock saturate the narrow error counter.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h00, 1'b0);
      cyc(1'b1, 8'h5A, 1'b0);
      cyc(1'b1, 8'hFF, 1'b0);
    end
    settle();
    chk("err_saturate", 32'(err_count_o), 7);
    chk("word_saturate", 32'(word_count_o), 7);
    chk("sat_still_locked", 32'(locked_o), 1);

    cyc(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
